// File: rtl/rle_pixel_source.sv
// Run-length token expander feeding the VGA colour input, frame-locked via SOF markers.
// Optional underrun pixel counter enabled by defining RLE_UNDERRUN_CNT_EN.
module rle_pixel_source #(
    parameter int         FIFO_DEPTH       = 4,
    parameter int         PIXELS_PER_FRAME = 307200,
    parameter logic [8:0] UNDERRUN_COLOUR  = 9'h1C0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        pixel_en,
    input  logic        frame_start,
    input  logic        clear_flags,
    output logic [8:0]  colour_out,
    output logic        playing,
    output logic        underrun,
    output logic        desync,
    output logic [1:0]  dbg_state
`ifdef RLE_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [18:0] LAST_PIX = 19'(PIXELS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fs_q;
    logic [8:0]  cur_colour_q, cur_colour_d;
    logic [5:0]  remaining_q, remaining_d;
    logic        cur_valid_q, cur_valid_d;
    logic [18:0] pix_cnt_q, pix_cnt_d;
    logic        underrun_q, desync_q;

    logic        empty, full, push, pop, fs_edge, need_load;
    logic        set_underrun, set_desync;
    logic [15:0] head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign push     = in_valid && !full;
    assign in_ready = !full;
    assign fs_edge  = frame_start && !fs_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

    always_comb begin
        state_d      = state_q;
        cur_colour_d = cur_colour_q;
        remaining_d  = remaining_q;
        cur_valid_d  = cur_valid_q;
        pix_cnt_d    = pix_cnt_q;
        pop          = 1'b0;
        need_load    = 1'b0;
        set_underrun = 1'b0;
        set_desync   = 1'b0;
        case (state_q)
            SEEK: begin
                if (!empty) begin
                    if (head[15]) state_d = ARMED;
                    else          pop     = 1'b1;
                end
            end
            ARMED: begin
                if (fs_edge && !empty && head[15]) begin
                    pop          = 1'b1;
                    cur_colour_d = head[8:0];
                    remaining_d  = head[14:9];
                    cur_valid_d  = 1'b1;
                    pix_cnt_d    = '0;
                    state_d      = PLAY;
                end
            end
            PLAY: begin
                // End of frame outranks a coincident frame_start edge.
                if (pixel_en && pix_cnt_q == LAST_PIX) begin
                    pix_cnt_d = pix_cnt_q + 19'd1;
                    if (!empty && !head[15]) begin
                        state_d    = SEEK;
                        set_desync = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end else if (fs_edge) begin
                    state_d    = SEEK;
                    set_desync = 1'b1;
                end else begin
                    if (pixel_en) begin
                        pix_cnt_d = pix_cnt_q + 19'd1;
                        if (cur_valid_q && remaining_q != 6'd0) remaining_d = remaining_q - 6'd1;
                        else                                    need_load   = 1'b1;
                    end else if (!cur_valid_q && !empty) begin
                        need_load = 1'b1;
                    end
                    if (need_load) begin
                        if (empty) begin
                            cur_valid_d  = 1'b0;
                            set_underrun = 1'b1;
                        end else if (head[15]) begin
                            state_d    = SEEK;
                            set_desync = 1'b1;
                        end else begin
                            pop          = 1'b1;
                            cur_colour_d = head[8:0];
                            remaining_d  = head[14:9];
                            cur_valid_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEEK;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fs_q         <= 1'b0;
            cur_colour_q <= '0;
            remaining_q  <= '0;
            cur_valid_q  <= 1'b0;
            pix_cnt_q    <= '0;
            underrun_q   <= 1'b0;
            desync_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fs_q         <= frame_start;
            cur_colour_q <= cur_colour_d;
            remaining_q  <= remaining_d;
            cur_valid_q  <= cur_valid_d;
            pix_cnt_q    <= pix_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            underrun_q   <= set_underrun || (underrun_q && !clear_flags);
            desync_q     <= set_desync || (desync_q && !clear_flags);
        end
    end

`ifdef RLE_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    logic        ucnt_inc;

    assign ucnt_inc = ((state_q == PLAY) && pixel_en && !cur_valid_q) || set_underrun;

    always_comb begin
        ucnt_d = ucnt_q;
        if (clear_flags)                     ucnt_d = ucnt_inc ? 16'd1 : 16'd0;
        else if (ucnt_inc && ucnt_q != '1)   ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ucnt_q <= '0;
        else        ucnt_q <= ucnt_d;
    end

    assign underrun_count = ucnt_q;
`endif

    assign colour_out = (state_q != PLAY) ? 9'h000 :
                        (cur_valid_q ? cur_colour_q : UNDERRUN_COLOUR);
    assign playing    = (state_q == PLAY);
    assign underrun   = underrun_q;
    assign desync     = desync_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rle_pixel_source.sv
// Directed and randomized bench for rle_pixel_source with a token-queue reference model.
module tb_rle_pixel_source;

    localparam int         PPF   = 8;
    localparam int         DEPTH = 4;
    localparam logic [8:0] UCOL  = 9'h1C0;
    localparam int M_SEEK = 0, M_ARMED = 1, M_PLAY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pixel_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        clear_flags = 1'b0;
    logic [8:0]  colour_out;
    logic        playing, underrun, desync;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: token queue plus "pixels left in current token".
    logic [15:0] mq[$];
    int          m_state;
    logic [8:0]  m_colour;
    int          m_left;
    bit          m_valid;
    int          m_cnt;
    bit          m_u, m_d, m_fs;

    rle_pixel_source #(
        .FIFO_DEPTH(DEPTH), .PIXELS_PER_FRAME(PPF), .UNDERRUN_COLOUR(UCOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pixel_en(pixel_en), .frame_start(frame_start),
        .clear_flags(clear_flags), .colour_out(colour_out), .playing(playing),
        .underrun(underrun), .desync(desync), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = M_SEEK; m_colour = '0; m_left = 0; m_valid = 0;
        m_cnt = 0; m_u = 0; m_d = 0; m_fs = 0;
    endtask

    task automatic model_take_head();
        logic [15:0] t;
        t = mq.pop_front();
        m_colour = t[8:0];
        m_left   = int'(t[14:9]) + 1;
        m_valid  = 1;
    endtask

    task automatic model_step(input bit push, input logic [15:0] data, input bit pen,
                              input bit fs, input bit clr);
        bit          fs_rise, su, sd, need;
        logic [15:0] h;
        fs_rise = fs && !m_fs;
        su = 0; sd = 0; need = 0;
        h = (mq.size() > 0) ? mq[0] : 16'h0000;
        case (m_state)
            M_SEEK: if (mq.size() > 0) begin
                if (h[15]) m_state = M_ARMED;
                else       void'(mq.pop_front());
            end
            M_ARMED: if (fs_rise && mq.size() > 0 && h[15]) begin
                model_take_head();
                m_cnt   = 0;
                m_state = M_PLAY;
            end
            default: begin
                if (pen && m_cnt == PPF - 1) begin
                    if (mq.size() > 0 && !h[15]) begin m_state = M_SEEK; sd = 1; end
                    else m_state = M_ARMED;
                end else if (fs_rise) begin
                    m_state = M_SEEK; sd = 1;
                end else begin
                    if (pen) begin
                        m_cnt++;
                        if (m_valid) m_left--;
                        need = !m_valid || (m_left == 0);
                    end else begin
                        need = !m_valid && (mq.size() > 0);
                    end
                    if (need) begin
                        if (mq.size() == 0) begin m_valid = 0; su = 1; end
                        else if (h[15])     begin m_state = M_SEEK; sd = 1; end
                        else                model_take_head();
                    end
                end
            end
        endcase
        if (push) mq.push_back(data);
        m_u  = su ? 1'b1 : (clr ? 1'b0 : m_u);
        m_d  = sd ? 1'b1 : (clr ? 1'b0 : m_d);
        m_fs = fs;
    endtask

    task automatic cycle();
        bit          push;
        logic [8:0]  ec;
        ec = (m_state != M_PLAY) ? 9'h000 : (m_valid ? m_colour : UCOL);
        chk("colour_out", 16'(colour_out), 16'(ec));
        chk("playing", 16'(playing), 16'(m_state == M_PLAY));
        chk("in_ready", 16'(in_ready), 16'(mq.size() < DEPTH));
        chk("underrun", 16'(underrun), 16'(m_u));
        chk("desync", 16'(desync), 16'(m_d));
        chk("state", 16'(dbg_state), 16'(m_state));
        push = in_valid && (mq.size() < DEPTH);
        @(posedge clk);
        model_step(push, in_data, pixel_en, frame_start, clear_flags);
        #1;
    endtask

    task automatic push_tok(input logic [15:0] t);
        in_valid = 1'b1;
        in_data  = t;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_tok();
        logic s;
        s = ($urandom_range(0, 5) == 0);
        return {s, 6'($urandom_range(0, 9)), 9'($urandom_range(0, 511))};
    endfunction

    initial begin
        logic [8:0] exp_dec [8];
        exp_dec = '{9'h007, 9'h007, 9'h007, 9'h038, 9'h038, 9'h038, 9'h038, 9'h038};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_colour", 16'(colour_out), 16'h0);
        chk("rst_playing", 16'(playing), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        chk("rst_flags", 16'({underrun, desync}), 16'h0);
        rst_n = 1'b1;

        // Preamble discard followed by basic decode
        push_tok({1'b0, 6'd5, 9'h1FF});
        push_tok({1'b0, 6'd1, 9'h0F0});
        push_tok({1'b1, 6'd2, 9'h007});
        push_tok({1'b0, 6'd4, 9'h038});
        repeat (2) cycle();
        chk("pre_armed", 16'(dbg_state), 16'(M_ARMED));
        chk("pre_no_desync", 16'(desync), 16'h0);
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        pixel_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("decode_px", 16'(colour_out), 16'(exp_dec[i]));
            cycle();
        end
        pixel_en = 1'b0;
        chk("decode_end_armed", 16'(dbg_state), 16'(M_ARMED));
        chk("decode_end_colour", 16'(colour_out), 16'h0);

        // Underrun and resume through a blanking refill
        push_tok({1'b1, 6'd1, 9'h0AA});
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        pixel_en = 1'b1;
        chk("ur_px1", 16'(colour_out), 16'h0AA); cycle();
        chk("ur_px2", 16'(colour_out), 16'h0AA); cycle();
        chk("ur_px3", 16'(colour_out), 16'(UCOL));
        chk("ur_flag", 16'(underrun), 16'h1); cycle();
        chk("ur_px4", 16'(colour_out), 16'(UCOL)); cycle();
        pixel_en = 1'b0;
        push_tok({1'b0, 6'd1, 9'h055});
        cycle();
        pixel_en = 1'b1;
        chk("ur_px5", 16'(colour_out), 16'h055); cycle();
        chk("ur_px6", 16'(colour_out), 16'h055); cycle();
        chk("ur_px7", 16'(colour_out), 16'(UCOL)); cycle();
        chk("ur_px8", 16'(colour_out), 16'(UCOL)); cycle();
        pixel_en = 1'b0;
        chk("ur_end_armed", 16'(dbg_state), 16'(M_ARMED));
        clear_flags = 1'b1; cycle(); clear_flags = 1'b0;
        chk("ur_cleared", 16'(underrun), 16'h0);

        // Short frame: SOF reaches the head mid-frame
        push_tok({1'b1, 6'd0, 9'h011});
        push_tok({1'b1, 6'd3, 9'h022});
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        pixel_en = 1'b1;
        chk("sf_px1", 16'(colour_out), 16'h011); cycle();
        pixel_en = 1'b0;
        chk("sf_desync", 16'(desync), 16'h1);
        chk("sf_seek", 16'(dbg_state), 16'(M_SEEK));
        cycle();
        chk("sf_armed", 16'(dbg_state), 16'(M_ARMED));
        clear_flags = 1'b1; cycle(); clear_flags = 1'b0;
        chk("sf_cleared", 16'(desync), 16'h0);

        // Long frame: frame_start edge at pix_cnt 3
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        pixel_en = 1'b1;
        repeat (3) cycle();
        pixel_en = 1'b0;
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        chk("lf_desync", 16'(desync), 16'h1);
        chk("lf_seek", 16'(dbg_state), 16'(M_SEEK));

        // Asynchronous reset mid-PLAY with a full FIFO
        push_tok({1'b1, 6'd5, 9'h0F0});
        cycle();
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        pixel_en = 1'b1;
        repeat (2) cycle();
        pixel_en = 1'b0;
        for (int i = 0; i < 4; i++) push_tok({1'b0, 6'd0, 9'(i + 1)});
        chk("full_in_ready", 16'(in_ready), 16'h0);
        chk("full_playing", 16'(playing), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_colour", 16'(colour_out), 16'h0);
        chk("arst_playing", 16'(playing), 16'h0);
        chk("arst_in_ready", 16'(in_ready), 16'h1);
        chk("arst_desync", 16'(desync), 16'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic against a regular line/blank cadence
        for (int i = 0; i < 600; i++) begin
            int pos;
            pos         = i % 12;
            pixel_en    = (pos < 8) ^ ($urandom_range(0, 39) == 0);
            frame_start = (pos == 9 || pos == 10);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = rand_tok();
            clear_flags = ($urandom_range(0, 63) == 0);
            cycle();
        end

        // Fully random traffic
        for (int i = 0; i < 600; i++) begin
            pixel_en    = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 9) == 0);
            in_valid    = ($urandom_range(0, 2) != 0);
            in_data     = rand_tok();
            clear_flags = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rle_pixel_source.md
# rle_pixel_source

Upstream feeder for the VGA timing unit. It accepts a run-length-encoded token stream, buffers it in a small FIFO, and expands it into one 9-bit rrrgggbbb pixel per active display cycle. Its `colour_out` drives the VGA unit's `colour_in`. It locks each encoded frame to the VGA frame boundary using start-of-frame (SOF) markers and the VGA `next_frame` output, and it reports underrun and desync conditions.

## Interface
- `FIFO_DEPTH`, default 4: token FIFO entries; power of two, ≥2.
- `PIXELS_PER_FRAME`, default 307200: pixels consumed per frame; max 2^19−1.
- `UNDERRUN_COLOUR`, default 9'h1C0: colour shown when no token is available.
- `clk` input 1: pixel clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `in_data` input 16: token `{sof[15], run[14:9], colour[8:0]}`. A token covers run+1 pixels (1..64).
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: equals FIFO not full.
- `pixel_en` input 1: one pixel is consumed this cycle. Driven by the VGA unit's `!blank`.
- `frame_start` input 1: VGA `next_frame` level. The block acts on its rising edge.
- `clear_flags` input 1: synchronous clear of the sticky flags.
- `colour_out` output 9: current pixel colour.
- `playing` output 1: state is PLAY.
- `underrun` output 1: sticky underrun flag.
- `desync` output 1: sticky frame-alignment error flag.

## Operation
- **FIFO**
  - Push when `in_valid && in_ready`. Pop is internal.
  - Push and pop in the same cycle are allowed, including when the FIFO is empty→1 or full→pop.
  - Read head is combinational.
- **Edge detect:** `fs_edge = frame_start && !fs_q`.
- **Current-token registers:** `cur_colour`, `remaining` (6b), `cur_valid`.
- **Pixel counter:** `pix_cnt`, 19 bits.
- **States:**
  - **SEEK:** pop and discard heads with sof=0. When the head has sof=1, do not pop it; go to ARMED.
  - **ARMED:** hold. On `fs_edge` with head sof=1: pop head into the cur registers, set `remaining=run`, `cur_valid=1`, `pix_cnt=0`, then go to PLAY.
  - **PLAY, pixel consumption:** on each `pixel_en` cycle, `pix_cnt++`. Then, if `cur_valid && remaining>0`, `remaining--`.
  - **PLAY, token exhausted:** if `remaining==0` or `!cur_valid`, load the head if the FIFO is non-empty. Otherwise set `cur_valid=0` and `underrun=1`.
  - **PLAY, blanking refill:** if `!cur_valid` and `pixel_en=0` and the FIFO is non-empty, load the head.
  - **PLAY, end of frame:** when the pixel with `pix_cnt==PIXELS_PER_FRAME−1` is consumed, go to ARMED with no load. If the head at that edge is present with sof=0, go to SEEK and set `desync` instead.
- **Desync triggers (all go to SEEK with `desync=1`):**
  - A load in PLAY whose head has sof=1 (short frame). The SOF token is not popped.
  - `fs_edge` in PLAY (long frame). The FIFO is not flushed; SEEK discards.
- **`colour_out`:**
  - PLAY with `cur_valid`: `cur_colour`.
  - PLAY with `!cur_valid`: `UNDERRUN_COLOUR`.
  - Otherwise: 0.
- **Flags:**
  - `clear_flags` clears `underrun` and `desync`.
  - If clear and set occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - State SEEK, FIFO empty, `in_ready=1`, `fs_q=0`.
  - `colour_out=0`, `playing=0`, `underrun=0`, `desync=0`.
  - `cur_valid=0`, `pix_cnt=0`.
- **Reset is asynchronous:** asserting `rst_n` mid-frame discards FIFO contents immediately.
- **Colour latency:** 0 cycles. `colour_out` is combinational from registers and is valid in the same cycle `pixel_en` is high. It advances on the edge that ends that cycle.
- **Token input:** a token pushed in cycle N is visible at the head in N+1.
- **Sustained rate:** sustaining 1 pixel/cycle with run=0 tokens requires 1 token/cycle.
- **ARMED→PLAY:** the transition occurs on the edge where `fs_edge` is sampled. The first pixel comes from the SOF token.
- **Simultaneous `fs_edge` and end-of-frame pixel in PLAY:** the end-of-frame rule wins (→ARMED). The edge is then consumed and is not re-seen.
- **Pixel counting:** `pix_cnt` counts underrun pixels too, so frame length stays aligned to VGA.

## Configuration
- `RLE_UNDERRUN_CNT_EN`
  - **Defined:** adds output `underrun_count[15:0]`. It increments once per underrun pixel (each `pixel_en` cycle in PLAY with `!cur_valid`, plus the cycle that sets `underrun`). It saturates at 16'hFFFF, resets to 0, and `clear_flags` clears it.
  - **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Basic decode:** `PIXELS_PER_FRAME=8`. Push `{1,6'd2,9'h007}`, `{0,6'd4,9'h038}`, pulse `frame_start`, then hold `pixel_en=1` for 8 cycles. Required: `colour_out` = 007×3 then 038×5; after the 8th pixel the state is ARMED and `colour_out=0`.
- **Preamble discard:** push two sof=0 tokens, then an SOF token. Required: the first two are discarded in SEEK, the block waits in ARMED with the SOF at head, and no `desync` is raised.
- **Underrun:** stall input after the first token (run=1) with `pixel_en=1`. Required: pixels 3+ show 9'h1C0 and `underrun=1`. A token pushed later resumes decode with its colour; `pix_cnt` still ends the frame at 8 pixels.
- **Short frame:** an SOF token arrives at the head mid-frame. Required: SEEK→ARMED with `desync=1`; `clear_flags` then drops `desync` to 0.
- **Long frame / reset:** a `frame_start` rising edge while `pix_cnt=3` sets `desync=1` and goes to SEEK. Asserting `rst_n=0` mid-PLAY immediately gives `colour_out=0`, `playing=0`, `in_ready=1`.
